servo_hle_seq: RTL and testbench

SERVO_HLE_SEQ -- requirements
Module: servo_hle_seq

---
 rtl/servo_hle_seq_if.sv | 11 +
 rtl/servo_hle_seq.sv | 174 +++++++++++++++++
 tb/tb_servo_hle_seq.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_hle_seq_if.sv
// Parallel byte-wide SPI link between the host sequencer and the servo
// emulation. The host strobes write for one cycle with mosi valid; the
// servo answers combinationally on miso in that same cycle.
interface parallel_spi;
  logic       write;
  logic [7:0] mosi;
  logic [7:0] miso;

  modport master (output write, output mosi, input miso);
  modport slave  (input write, input mosi, output miso);
endinterface

// File: rtl/servo_hle_seq.sv
// High-level emulation of the servo command sequence. A 0xB0 command opens
// a frame: three acknowledge bytes, a long quiet gap, five status bytes
// carrying the disc type, then a drain delay back to idle. A mode-fault
// counter paces the host between bytes, and a watchdog aborts a frame when
// the host stalls in a phase that is waiting for bytes.
module servo_hle_seq #(
  parameter int CNT_W    = 15,
  parameter int MF_SHORT = 80,
  parameter int MF_LONG  = 767,
  parameter int TO_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  parallel_spi.slave spi,
  input  logic [1:0] disc_type,
  output logic       quirk_force_mode_fault,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACK    = 3'd1,
    GAP    = 3'd2,
    STATUS = 3'd3,
    DRAIN  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(MF_SHORT);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(MF_LONG);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             quirk_q, busy_q, frame_done_q, timeout_q;

  logic             load_short, load_long, to_hit;
  logic [7:0]       disc_byte;

  // Disc-type code reported in the fourth status byte; the reserved code
  // reads back as CD-i.
  always_comb begin
    case (disc_type)
      2'd0:    disc_byte = 8'h00;
      2'd1:    disc_byte = 8'h01;
      default: disc_byte = 8'h02;
    endcase
  end

  // Next-state, reply byte and counter load requests.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    spi.miso   = 8'hFF;
    load_short = 1'b0;
    load_long  = 1'b0;
    // The watchdog only runs while the host owes us bytes.
    to_hit     = ((state_q == ACK) || (state_q == STATUS)) && (to_q == '1);

    if (to_hit) begin
      state_d = IDLE;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (spi.write) begin
            if (spi.mosi == 8'hDD) begin
              spi.miso = 8'hEE;
            end else if (spi.mosi == 8'hB0) begin
              spi.miso   = 8'h55;
              load_short = 1'b1;
              idx_d      = 3'd0;
              state_d    = ACK;
            end
          end
        end
        ACK: begin
          if (spi.write) begin
            spi.miso   = (idx_q == 3'd0) ? 8'h61 : 8'h01;
            load_short = 1'b1;
            idx_d      = idx_q + 3'd1;
            if (idx_q >= 3'd2) state_d = GAP;
          end
        end
        GAP: begin
          // Host writes here are answered with 0xFF and otherwise ignored.
          if (cnt_q == '0) begin
            load_long = 1'b1;
            idx_d     = 3'd0;
            state_d   = STATUS;
          end
        end
        STATUS: begin
          if (spi.write) begin
            case (idx_q)
              3'd0:    spi.miso = 8'h03;
              3'd1:    spi.miso = 8'hB0;
              3'd2:    spi.miso = 8'h00;
              3'd3:    spi.miso = disc_byte;
              default: spi.miso = 8'h25;
            endcase
            load_short = 1'b1;
            idx_d      = idx_q + 3'd1;
            if (idx_q >= 3'd4) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_q == '0) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  // Mode-fault counter: an abort clears it, a load beats the decrement,
  // and it rests at zero.
  always_comb begin
    if (to_hit)              cnt_d = '0;
    else if (load_long)      cnt_d = LONG_LD;
    else if (load_short)     cnt_d = SHORT_LD;
    else if (cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
    else                     cnt_d = cnt_q;
  end

  // Watchdog: restarts on any host byte or phase change, counts only in
  // the phases that wait for the host.
  always_comb begin
    if (to_hit || spi.write || (state_d != state_q))
      to_d = '0;
    else if ((state_q == ACK) || (state_q == STATUS))
      to_d = to_q + TO_W'(1);
    else
      to_d = to_q;
  end

  // State, counters and registered status pulses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      cnt_q        <= '0;
      to_q         <= '0;
      quirk_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      // An abort swallows a fault that would otherwise fire on this edge.
      quirk_q      <= (cnt_q == CNT_W'(1)) && !to_hit;
      busy_q       <= (state_q != IDLE);
      frame_done_q <= (state_q == DRAIN) && (cnt_q == '0) && !to_hit;
      timeout_q    <= to_hit;
    end
  end

  assign quirk_force_mode_fault = quirk_q;
  assign busy                   = busy_q;
  assign frame_done             = frame_done_q;
  assign timeout_err            = timeout_q;

endmodule

// File: tb/tb_servo_hle_seq.sv
// Bench for servo_hle_seq: a reply-byte vector table, hand-written timing
// sequences for the mode-fault, gap, timeout and reset cases, and a random
// run compared with a transaction-level reference model.
module tb_servo_hle_seq;

  localparam int MF_SHORT = 80;
  localparam int MF_LONG  = 767;
  localparam int TO_W     = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] disc_type;
  logic       quirk, busy, frame_done, timeout_err;

  parallel_spi spi ();

  servo_hle_seq #(
    .CNT_W(15), .MF_SHORT(MF_SHORT), .MF_LONG(MF_LONG), .TO_W(TO_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .spi(spi),
    .disc_type(disc_type),
    .quirk_force_mode_fault(quirk),
    .busy(busy),
    .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Values seen in the middle of the last stepped cycle.
  logic [7:0] s_miso;
  logic       s_quirk, s_busy, s_fd, s_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive just after the rising edge, sample at the
  // falling edge.
  task automatic step(input logic w, input logic [7:0] m, input logic [1:0] d);
    spi.write = w;
    spi.mosi  = m;
    disc_type = d;
    @(negedge clk);
    s_miso  = spi.miso;
    s_quirk = quirk;
    s_busy  = busy;
    s_fd    = frame_done;
    s_to    = timeout_err;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h5A, disc_type);
  endtask

  // Number of idle cycles until the next mode-fault pulse (bound if none).
  task automatic wait_quirk(input int bound, output int n);
    n = 0;
    do begin
      step(1'b0, 8'h5A, disc_type);
      n++;
    end while (!s_quirk && n < bound);
  endtask

  // Back-to-back frame; returns the disc byte of the status phase.
  task automatic run_frame(input logic [1:0] d, output logic [7:0] dbyte);
    step(1'b1, 8'hB0, d);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h00, d);
    idle(MF_SHORT + 10);
    dbyte = 8'hXX;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'hAA, d);
      if (i == 3) dbyte = s_miso;
    end
    idle(MF_SHORT + 10);
  endtask

  // ---------------- reference model (random phase) -----------------
  // A frame is tracked as the count of payload bytes accepted after the
  // 0xB0 command plus the cycle at which the status window opens and the
  // cycle the frame closes. Mode-fault pulses are a list of future cycles.
  int pulses[$];

  task automatic mf_load(input int t, input int delay);
    int keep[$];
    // A reload at cycle t sets the counter at t+1, so any pulse that
    // would have appeared at t+2 or later is superseded.
    foreach (pulses[i]) if (pulses[i] < t + 2) keep.push_back(pulses[i]);
    pulses = keep;
    pulses.push_back(t + delay + 1);
  endtask

  function automatic logic [7:0] status_byte(input int n, input logic [1:0] d);
    case (n)
      0:       return 8'h03;
      1:       return 8'hB0;
      2:       return 8'h00;
      3:       return (d == 2'd0) ? 8'h00 : (d == 2'd1) ? 8'h01 : 8'h02;
      default: return 8'h25;
    endcase
  endfunction

  typedef struct {
    string      name;
    int         pre;
    logic [7:0] mosi;
    logic [1:0] disc;
    logic [7:0] exp_miso;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int         n, qcount, fdcount;
    logic [7:0] dbyte;
    logic [7:0] ack_tab[3];
    logic [7:0] sb0[4];
    logic [7:0] sb1[4];

    ack_tab = '{8'h61, 8'h01, 8'h01};
    sb0     = '{8'hB0, 8'h00, 8'h00, 8'h00};
    sb1     = '{8'h55, 8'h61, 8'h01, 8'h01};

    // pre = idle cycles before the write.
    vecs[0]  = '{"idle_dd",    2,   8'hDD, 2'd0, 8'hEE, 1'b0};
    vecs[1]  = '{"cmd_b0",     0,   8'hB0, 2'd0, 8'h55, 1'b0};
    vecs[2]  = '{"ack0",       100, 8'h00, 2'd0, 8'h61, 1'b1};
    vecs[3]  = '{"ack1_dd",    100, 8'hDD, 2'd0, 8'h01, 1'b1};
    vecs[4]  = '{"ack2_b0",    100, 8'hB0, 2'd0, 8'h01, 1'b1};
    vecs[5]  = '{"gap_write",  10,  8'hAA, 2'd0, 8'hFF, 1'b1};
    vecs[6]  = '{"st0",        80,  8'hAA, 2'd2, 8'h03, 1'b1};
    vecs[7]  = '{"st1_b0",     0,   8'hB0, 2'd2, 8'hB0, 1'b1};
    vecs[8]  = '{"st2_dd",     3,   8'hDD, 2'd2, 8'h00, 1'b1};
    vecs[9]  = '{"st3_disc",   0,   8'hAA, 2'd2, 8'h02, 1'b1};
    vecs[10] = '{"st4",        0,   8'hAA, 2'd0, 8'h25, 1'b1};
    vecs[11] = '{"drain_wr",   5,   8'hAA, 2'd0, 8'hFF, 1'b1};

    // ---- reset state ----
    reset = 1'b1;
    spi.write = 1'b0; spi.mosi = 8'h00; disc_type = 2'd0;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 2'd0);
    check("rst_miso",  s_miso,  8'hFF);
    check("rst_busy",  s_busy,  1'b0);
    check("rst_quirk", s_quirk, 1'b0);
    check("rst_fd",    s_fd,    1'b0);
    check("rst_to",    s_to,    1'b0);
    reset = 1'b0;

    // ---- vector table: reply bytes across a whole frame ----
    foreach (vecs[i]) begin
      idle(vecs[i].pre);
      step(1'b1, vecs[i].mosi, vecs[i].disc);
      check({vecs[i].name, "_miso"}, s_miso, vecs[i].exp_miso);
      check({vecs[i].name, "_busy"}, s_busy, vecs[i].exp_busy);
    end
    fdcount = 0;
    for (int i = 0; i < 150; i++) begin
      step(1'b0, 8'h00, 2'd0);
      fdcount += int'(s_fd);
    end
    check("tab_frame_done_cnt", fdcount, 1);
    check("tab_busy_end", s_busy, 1'b0);

    // ---- mode-fault spacing and gap length ----
    for (int i = 0; i < 4; i++) begin
      step(1'b1, sb0[i], 2'd2);
      check("mf_reply", s_miso, sb1[i]);
      wait_quirk(200, n);
      check("mf_delay", n, MF_SHORT + 1);
      if (i < 3) idle(100 - (MF_SHORT + 1) - 1);
    end
    wait_quirk(2000, n);
    check("gap_pulse_delay", n, MF_LONG + 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'hAA, 2'd2);
      check("frame_st_byte", s_miso, status_byte(i, 2'd2));
    end
    fdcount = 0;
    for (int i = 0; i < 150; i++) begin
      step(1'b0, 8'h00, 2'd2);
      fdcount += int'(s_fd);
    end
    check("frame_done_once", fdcount, 1);

    // ---- disc type across two frames ----
    run_frame(2'd1, dbyte);
    check("disc_cd", dbyte, 8'h01);
    run_frame(2'd0, dbyte);
    check("disc_empty", dbyte, 8'h00);

    // ---- host stall in the status phase ----
    step(1'b1, 8'hB0, 2'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 2'd1);
    idle(MF_SHORT + 10);
    step(1'b1, 8'hAA, 2'd1);
    check("to_st0", s_miso, 8'h03);
    step(1'b1, 8'hAA, 2'd1);
    check("to_st1", s_miso, 8'hB0);
    n = 0;
    qcount = 0;
    do begin
      step(1'b0, 8'h00, 2'd1);
      n++;
      qcount += int'(s_quirk);
    end while (!s_to && n < 70000);
    // The watchdog restarts after the last byte and needs 2^TO_W-1 further
    // counts; the abort then shows one cycle later.
    check("to_delay", n, (1 << TO_W) + 1);
    check("to_no_quirk", s_quirk, 1'b0);
    check("to_busy_at_err", s_busy, 1'b1);
    check("to_quirk_count", qcount, 1);
    step(1'b0, 8'h00, 2'd1);
    check("to_busy_after", s_busy, 1'b0);
    check("to_pulse_len", s_to, 1'b0);
    step(1'b1, 8'hB0, 2'd1);
    check("to_next_b0", s_miso, 8'h55);

    // ---- reset in the middle of the acknowledge phase ----
    step(1'b1, 8'h00, 2'd1);
    check("rst_ack0", s_miso, 8'h61);
    idle(3);
    reset = 1'b1;
    step(1'b1, 8'h00, 2'd1);
    reset = 1'b0;
    step(1'b1, 8'hB0, 2'd1);
    check("mid_rst_b0",    s_miso,  8'h55);
    check("mid_rst_busy",  s_busy,  1'b0);
    check("mid_rst_quirk", s_quirk, 1'b0);
    check("mid_rst_fd",    s_fd,    1'b0);
    check("mid_rst_to",    s_to,    1'b0);

    // ---- random traffic against the reference model ----
    reset = 1'b1;
    step(1'b0, 8'h00, 2'd0);
    reset = 1'b0;
    begin
      bit         in_frame = 1'b0;
      bit         prev_nonidle = 1'b0;
      int         nbytes = 0;
      int         t_open = 0;
      int         t_idle = 0;
      logic       w;
      logic [7:0] m;
      logic [1:0] d;
      logic [7:0] exp_miso;
      logic       exp_busy, exp_fd, exp_quirk;
      int         r;
      pulses.delete();
      for (int c = 0; c < 6000; c++) begin
        w = ($urandom_range(0, 29) == 0);
        r = $urandom_range(0, 9);
        m = (r < 5) ? 8'hB0 : (r < 7) ? 8'hDD : 8'($urandom_range(0, 255));
        d = 2'($urandom_range(0, 3));

        exp_fd = 1'b0;
        if (in_frame && nbytes == 8 && c == t_idle) begin
          in_frame = 1'b0;
          exp_fd   = 1'b1;
        end
        exp_busy     = prev_nonidle;
        prev_nonidle = in_frame;
        exp_miso     = 8'hFF;
        if (w) begin
          if (!in_frame) begin
            if (m == 8'hDD) exp_miso = 8'hEE;
            else if (m == 8'hB0) begin
              exp_miso = 8'h55;
              in_frame = 1'b1;
              nbytes   = 0;
              mf_load(c, MF_SHORT);
            end
          end else if (nbytes < 3) begin
            exp_miso = ack_tab[nbytes];
            nbytes++;
            mf_load(c, MF_SHORT);
            if (nbytes == 3) begin
              // Gap ends when the short delay has run out; the long delay
              // is loaded on that cycle.
              mf_load(c + MF_SHORT + 1, MF_LONG);
              t_open = c + MF_SHORT + 2;
            end
          end else if (nbytes < 8 && c >= t_open) begin
            exp_miso = status_byte(nbytes - 3, d);
            nbytes++;
            mf_load(c, MF_SHORT);
            if (nbytes == 8) t_idle = c + MF_SHORT + 2;
          end
        end
        exp_quirk = 1'b0;
        foreach (pulses[i]) if (pulses[i] == c) exp_quirk = 1'b1;

        step(w, m, d);
        check("rnd_miso",  s_miso,  exp_miso);
        check("rnd_busy",  s_busy,  exp_busy);
        check("rnd_fd",    s_fd,    exp_fd);
        check("rnd_quirk", s_quirk, exp_quirk);
        check("rnd_to",    s_to,    1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
